// File: rtl/compare15_table.sv
// compare15_table: register file and handshake front end for the 15-entry
// compare15 matcher. It holds the table and registers the search key. After
// one evaluation cycle it captures the matcher's verdict into a held result
// and keeps saturating hit/miss statistics.
module compare15_table #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [3:0]         wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               srch_valid,
    input  logic [7:0]         srch_key,
    output logic               srch_ready,
    output logic [7:0]         cmp_key,
    output logic [119:0]       ent_bus,
    input  logic               cmp_match,
    input  logic [3:0]         cmp_index,
    output logic               rslt_valid,
    input  logic               rslt_ready,
    output logic               rslt_match,
    output logic [3:0]         rslt_index,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    // Table depth is fixed by the matcher.
    localparam int N_ENT = 15;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        key_q, key_d;
    logic              rslt_valid_q, rslt_valid_d;
    logic              rslt_match_q, rslt_match_d;
    logic [3:0]        rslt_index_q, rslt_index_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic              hit_inc, miss_inc;

    // Table entries. Address 15 matches no entry, so writes to it are
    // dropped. Writes land in any state; a search in EVAL sees the pre-edge
    // value because the capture happens on the same edge as the write.
    genvar gi;
    generate
        for (gi = 0; gi < N_ENT; gi++) begin : g_ent
            logic [7:0] ent_q;

            // Per-entry storage with write strobe decode.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_q <= 8'h00;
                end else if (wr_en && (wr_addr == 4'(gi))) begin
                    ent_q <= wr_data;
                end
            end

            assign ent_bus[8*gi +: 8] = ent_q;
        end
    endgenerate

    // State, key, result and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_q        <= 8'h00;
            rslt_valid_q <= 1'b0;
            rslt_match_q <= 1'b0;
            rslt_index_q <= 4'd0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            rslt_valid_q <= rslt_valid_d;
            rslt_match_q <= rslt_match_d;
            rslt_index_q <= rslt_index_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Next-state logic: accept in IDLE, capture in EVAL, hold in RESP.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        rslt_valid_d = rslt_valid_q;
        rslt_match_d = rslt_match_q;
        rslt_index_d = rslt_index_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (srch_valid) begin
                    key_d   = srch_key;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rslt_match_d = cmp_match;
                rslt_index_d = cmp_match ? cmp_index : 4'd0;
                rslt_valid_d = 1'b1;
                hit_inc      = cmp_match;
                miss_inc     = ~cmp_match;
                state_d      = RESP;
            end
            RESP: begin
                if (rslt_ready) begin
                    rslt_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating statistics; a clear beats a same-cycle increment.
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (clr_cnt) begin
            hit_d  = '0;
            miss_d = '0;
        end else begin
            if (hit_inc && (hit_q != CNT_MAX)) begin
                hit_d = hit_q + CNT_W'(1);
            end
            if (miss_inc && (miss_q != CNT_MAX)) begin
                miss_d = miss_q + CNT_W'(1);
            end
        end
    end

    assign srch_ready = (state_q == IDLE);
    assign cmp_key    = key_q;
    assign rslt_valid = rslt_valid_q;
    assign rslt_match = rslt_match_q;
    assign rslt_index = rslt_index_q;
    assign hit_cnt    = hit_q;
    assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_compare15_table.sv
// Directed bench for compare15_table. A behavioural lowest-index matcher
// stands in for compare15. A second instance with 4-bit counters exercises
// saturation in a short run.
module tb_compare15_table;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         srch_valid;
    logic [7:0]   srch_key;
    logic         rslt_ready;
    logic         clr_cnt;

    logic         srch_ready, rslt_valid, rslt_match;
    logic [7:0]   cmp_key;
    logic [119:0] ent_bus;
    logic         cmp_match;
    logic [3:0]   cmp_index, rslt_index;
    logic [15:0]  hit_cnt, miss_cnt;

    logic         s_srch_ready, s_rslt_valid, s_rslt_match;
    logic [7:0]   s_cmp_key;
    logic [119:0] s_ent_bus;
    logic         s_cmp_match;
    logic [3:0]   s_cmp_index, s_rslt_index;
    logic [3:0]   s_hit_cnt, s_miss_cnt;

    logic [7:0]   tab [15];
    int           n_chk = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    compare15_table dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .srch_valid(srch_valid), .srch_key(srch_key), .srch_ready(srch_ready),
        .cmp_key(cmp_key), .ent_bus(ent_bus), .cmp_match(cmp_match), .cmp_index(cmp_index),
        .rslt_valid(rslt_valid), .rslt_ready(rslt_ready), .rslt_match(rslt_match),
        .rslt_index(rslt_index), .clr_cnt(clr_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    compare15_table #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .srch_valid(srch_valid), .srch_key(srch_key), .srch_ready(s_srch_ready),
        .cmp_key(s_cmp_key), .ent_bus(s_ent_bus), .cmp_match(s_cmp_match), .cmp_index(s_cmp_index),
        .rslt_valid(s_rslt_valid), .rslt_ready(rslt_ready), .rslt_match(s_rslt_match),
        .rslt_index(s_rslt_index), .clr_cnt(clr_cnt), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    // Stand-in for compare15: lowest matching index wins.
    function automatic logic [4:0] match_of(input logic [119:0] bus, input logic [7:0] key);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 14; i >= 0; i--) begin
            if (bus[8*i +: 8] == key) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    always_comb {cmp_match, cmp_index}     = match_of(ent_bus, cmp_key);
    always_comb {s_cmp_match, s_cmp_index} = match_of(s_ent_bus, s_cmp_key);

    function automatic logic [119:0] exp_bus();
        logic [119:0] b;
        b = '0;
        for (int i = 0; i < 15; i++) b[8*i +: 8] = tab[i];
        return b;
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        if (a < 4'd15) tab[a] = d;
        check_val("ent_bus_after_wr", ent_bus, exp_bus());
    endtask

    // Present a key for one cycle; afterwards the DUT sits in EVAL.
    task automatic search_start(input logic [7:0] key);
        srch_valid = 1'b1; srch_key = key;
        step();
        srch_valid = 1'b0;
        check_val("eval_no_valid", rslt_valid, 0);
        check_val("eval_not_ready", srch_ready, 0);
        check_val("eval_cmp_key", cmp_key, key);
    endtask

    // Close EVAL and check the captured result.
    task automatic search_result(input logic m, input logic [3:0] idx,
                                 input logic [15:0] hit, input logic [15:0] miss);
        step();
        check_val("rslt_valid", rslt_valid, 1);
        check_val("rslt_match", rslt_match, m);
        check_val("rslt_index", rslt_index, idx);
        check_val("hit_cnt", hit_cnt, hit);
        check_val("miss_cnt", miss_cnt, miss);
    endtask

    task automatic accept();
        rslt_ready = 1'b1;
        step();
        rslt_ready = 1'b0;
        check_val("idle_ready", srch_ready, 1);
        check_val("idle_no_valid", rslt_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
        srch_valid = 1'b0; srch_key = 8'h00; rslt_ready = 1'b0; clr_cnt = 1'b0;
        for (int i = 0; i < 15; i++) tab[i] = 8'h00;
        #3;
        check_val("rst_srch_ready", srch_ready, 1);
        check_val("rst_rslt_valid", rslt_valid, 0);
        check_val("rst_rslt_match", rslt_match, 0);
        check_val("rst_rslt_index", rslt_index, 0);
        check_val("rst_cmp_key", cmp_key, 0);
        check_val("rst_ent_bus", ent_bus, 0);
        check_val("rst_hit", hit_cnt, 0);
        check_val("rst_miss", miss_cnt, 0);
        #4 rst_n = 1'b1;
        step();

        // Immediate search of 00 against an all-zero table.
        search_start(8'h00);
        search_result(1'b1, 4'd0, 16'd1, 16'd0);
        accept();

        // Hit then miss.
        wr(4'd9, 8'hA5);
        search_start(8'hA5);
        search_result(1'b1, 4'd9, 16'd2, 16'd0);
        accept();
        search_start(8'h3C);
        search_result(1'b0, 4'd0, 16'd2, 16'd1);
        accept();

        // Address 15 does not exist.
        wr(4'd15, 8'hEE);

        // Duplicates: lowest index wins; a write in EVAL is not seen.
        wr(4'd4, 8'h77);
        wr(4'd12, 8'h77);
        search_start(8'h77);
        search_result(1'b1, 4'd4, 16'd3, 16'd1);
        accept();
        search_start(8'h77);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h00;
        search_result(1'b1, 4'd4, 16'd4, 16'd1);
        wr_en = 1'b0; tab[4] = 8'h00;
        check_val("ent4_cleared", ent_bus[39:32], 8'h00);
        accept();
        search_start(8'h77);
        search_result(1'b1, 4'd12, 16'd5, 16'd1);
        accept();

        // Backpressure with an ignored search pulse.
        search_start(8'h77);
        search_result(1'b1, 4'd12, 16'd6, 16'd1);
        for (int c = 0; c < 10; c++) begin
            srch_valid = (c == 4); srch_key = 8'h55;
            step();
            check_val("bp_valid", rslt_valid, 1);
            check_val("bp_ready", srch_ready, 0);
            check_val("bp_index", rslt_index, 4'd12);
            check_val("bp_hit", hit_cnt, 16'd6);
        end
        srch_valid = 1'b0;
        accept();
        check_val("bp_key_kept", cmp_key, 8'h77);
        step();
        check_val("bp_no_extra", rslt_valid, 0);

        // Saturation (narrow instance) and plain clear.
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        check_val("clr_hit", hit_cnt, 0);
        check_val("clr_miss", miss_cnt, 0);
        for (int k = 0; k < 17; k++) begin
            search_start(8'h77);
            search_result(1'b1, 4'd12, 16'(k + 1), 16'd0);
            accept();
        end
        check_val("sat_small_hit", s_hit_cnt, 4'hF);
        check_val("nosat_main_hit", hit_cnt, 16'd17);
        search_start(8'h3C);
        search_result(1'b0, 4'd0, 16'd17, 16'd1);
        accept();
        check_val("small_miss", s_miss_cnt, 4'd1);

        // Clear on the same edge as an increment.
        search_start(8'h77);
        clr_cnt = 1'b1;
        search_result(1'b1, 4'd12, 16'd0, 16'd0);
        clr_cnt = 1'b0;
        check_val("clr_win_small_hit", s_hit_cnt, 4'd0);
        check_val("clr_win_small_miss", s_miss_cnt, 4'd0);
        accept();
        search_start(8'hA5);
        search_result(1'b1, 4'd9, 16'd1, 16'd0);
        accept();

        // Asynchronous reset in the middle of EVAL.
        search_start(8'h77);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_ready", srch_ready, 1);
        check_val("arst_valid", rslt_valid, 0);
        check_val("arst_key", cmp_key, 0);
        check_val("arst_ent_bus", ent_bus, 0);
        check_val("arst_hit", hit_cnt, 0);
        check_val("arst_index", rslt_index, 0);
        for (int i = 0; i < 15; i++) tab[i] = 8'h00;
        step();
        check_val("arst_hold_valid", rslt_valid, 0);
        #3 rst_n = 1'b1;
        step();
        check_val("arst_post_valid", rslt_valid, 0);
        step();
        check_val("arst_post_valid2", rslt_valid, 0);
        check_val("arst_post_hit", hit_cnt, 0);
        search_start(8'h00);
        search_result(1'b1, 4'd0, 16'd1, 16'd0);
        accept();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
